// File: rtl/rename_pkg.sv
// Shared parameters, pointer/tag types and controller states for the rename free list.
package rename_pkg;

  localparam int PRF_WIDTH   = 6;
  localparam int NUM_PRF     = 64;
  localparam int NUM_ARCH    = 32;
  localparam int WIDTH       = 4;
  localparam int PTR_WIDTH   = PRF_WIDTH + 1;
  localparam int INIT_CYCLES = (NUM_PRF - NUM_ARCH) / WIDTH;

  typedef logic [PTR_WIDTH-1:0] ptr_t;
  typedef logic [PRF_WIDTH-1:0] ptag_t;

  typedef enum logic [1:0] {
    INIT    = 2'd0,
    RUN     = 2'd1,
    RECOVER = 2'd2
  } fl_state_e;

endpackage

// File: rtl/lane_compact4.sv
// Prefix popcount of a 4-lane mask: per-lane slot offset (2 bits per lane) plus the total.
module lane_compact4
  import rename_pkg::*;
(
  input  logic [WIDTH-1:0] mask,
  output logic [7:0]       offs,
  output logic [2:0]       total
);

  always_comb begin
    offs[1:0] = 2'd0;
    offs[3:2] = 2'(mask[0]);
    offs[5:4] = 2'(mask[0]) + 2'(mask[1]);
    offs[7:6] = 2'(mask[0]) + 2'(mask[1]) + 2'(mask[2]);
    total     = 3'(mask[0]) + 3'(mask[1]) + 3'(mask[2]) + 3'(mask[3]);
  end

endmodule

// File: rtl/rename_freelist_ctrl.sv
// Physical-register free list for the 4-wide rename stage: all-or-nothing allocation,
// commit-side release and flush restore. Define FL_PERF_EN to add stall/low-water counters.
//
// state   | meaning
// INIT    | seeding tags NUM_ARCH..NUM_PRF-1 into the FIFO, 4 per cycle
// RUN     | allocation, commit, release and flush active
// RECOVER | one bubble after flush; commit/release still processed
module rename_freelist_ctrl
  import rename_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  alloc_req,
  output logic        alloc_gnt,
  output logic [23:0] alloc_prd,
  input  logic [2:0]  cmt_num,
  input  logic [3:0]  rel_vld,
  input  logic [23:0] rel_prd,
  input  logic        flush,
  output logic        ready,
  output logic [6:0]  free_cnt
`ifdef FL_PERF_EN
  , output logic [31:0] stall_cycles
  , output logic [6:0]  min_free
`endif
);

  fl_state_e state, state_nxt;
  ptr_t      rptr, crptr, wptr;
  ptr_t      cmt_ptr;
  ptag_t     mem [NUM_PRF];
  logic [2:0] init_cnt;

  logic [7:0] alloc_offs, rel_offs;
  logic [2:0] need, rel_cnt;
  logic [3:0] rel_mask;
  logic [7:0] occ_after;
  logic       run, rel_active, rel_overflow, rel_ok;
  ptag_t      alloc_idx [WIDTH];
  ptag_t      rel_idx   [WIDTH];
  ptag_t      init_idx  [WIDTH];

  lane_compact4 u_alloc_cmp (
    .mask  (alloc_req),
    .offs  (alloc_offs),
    .total (need)
  );

  // Tag 0 releases are dropped before compaction so they never occupy a slot.
  always_comb begin
    rel_mask = '0;
    for (int k = 0; k < WIDTH; k++)
      rel_mask[k] = rel_vld[k] && (rel_prd[PRF_WIDTH*k +: PRF_WIDTH] != '0);
  end

  lane_compact4 u_rel_cmp (
    .mask  (rel_mask),
    .offs  (rel_offs),
    .total (rel_cnt)
  );

  assign run          = (state == RUN);
  assign ready        = run;
  assign free_cnt     = wptr - rptr;
  assign cmt_ptr      = crptr + ptr_t'(cmt_num);
  assign rel_active   = (state != INIT);
  assign occ_after    = {1'b0, ptr_t'(wptr - crptr)} + {5'd0, rel_cnt};
  assign rel_overflow = (occ_after > 8'(NUM_PRF));
  assign rel_ok       = rel_active && !rel_overflow;
  assign alloc_gnt    = run && (need != 3'd0) && ({4'd0, need} <= free_cnt) && !flush;

  always_comb begin
    for (int k = 0; k < WIDTH; k++) begin
      alloc_idx[k] = rptr[PRF_WIDTH-1:0] + ptag_t'(alloc_offs[2*k +: 2]);
      rel_idx[k]   = wptr[PRF_WIDTH-1:0] + ptag_t'(rel_offs[2*k +: 2]);
      init_idx[k]  = wptr[PRF_WIDTH-1:0] + ptag_t'(k);
    end
  end

  always_comb begin
    alloc_prd = '0;
    if (run) begin
      for (int k = 0; k < WIDTH; k++)
        alloc_prd[PRF_WIDTH*k +: PRF_WIDTH] = mem[alloc_idx[k]];
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      INIT:    if (init_cnt == 3'd0) state_nxt = RUN;
      RUN:     if (flush) state_nxt = RECOVER;
      RECOVER: state_nxt = RUN;
      default: state_nxt = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= INIT;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rptr     <= '0;
      crptr    <= '0;
      wptr     <= '0;
      init_cnt <= 3'(INIT_CYCLES - 1);
    end else begin
      case (state)
        INIT: begin
          wptr <= wptr + ptr_t'(WIDTH);
          if (init_cnt != 3'd0) init_cnt <= init_cnt - 3'd1;
        end
        RUN, RECOVER: begin
          crptr <= cmt_ptr;
          // Flush restores the speculative head to the commit head after this cycle's commits.
          if (run && flush)   rptr <= cmt_ptr;
          else if (alloc_gnt) rptr <= rptr + ptr_t'(need);
          if (rel_ok) wptr <= wptr + ptr_t'(rel_cnt);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == INIT) begin
        for (int k = 0; k < WIDTH; k++)
          mem[init_idx[k]] <= ptag_t'(NUM_ARCH) + init_idx[k];
      end else if (rel_ok) begin
        for (int k = 0; k < WIDTH; k++)
          if (rel_mask[k]) mem[rel_idx[k]] <= rel_prd[PRF_WIDTH*k +: PRF_WIDTH];
      end
    end
  end

  a_cmt_not_past_alloc: assert property (@(posedge clk) disable iff (rst)
    (state != INIT) |-> (ptr_t'(rptr - crptr) >= {4'd0, cmt_num}));

  a_cmt_range: assert property (@(posedge clk) disable iff (rst)
    (state != INIT) |-> (cmt_num <= 3'd4));

  a_rel_no_overflow: assert property (@(posedge clk) disable iff (rst)
    rel_active |-> !rel_overflow);

`ifdef FL_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
      min_free     <= 7'd64;
    end else if (run) begin
      if ((need != 3'd0) && !alloc_gnt && !flush && (stall_cycles != '1))
        stall_cycles <= stall_cycles + 32'd1;
      if (free_cnt < min_free) min_free <= free_cnt;
    end
  end
`else
  // Counters are absent in this build.
`endif

endmodule
